rr_requester: RTL

Requester-side agent for one port of the 4-port parking round-robin arbiter. Queues burst commands, raises `req`, streams the burst while its `gnt` bit is held, then drops `req` and waits for the arbiter to release the grant so the pointer can rotate. Also flags starvation and grant-protocol violations. One instance connects to each arbiter port.

---
 rtl/rr_requester.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rr_requester.sv
// rr_requester: requester-side agent for one port of the parking round-robin arbiter.
// Queues burst commands, requests the port, streams beats while granted, then
// releases and waits for the grant to drop before requesting again.
module rr_requester #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_seed,
    output logic              req,
    input  logic              gnt,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_last,
    output logic              busy,
    output logic              starve,
    output logic              gnt_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned STV_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] TIMEOUT_C = STV_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [LEN_W-1:0]  mem_len  [DEPTH];
    logic [DATA_W-1:0] mem_seed [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_next;
    logic [LEN_W-1:0]  beat_idx;
    logic [STV_W-1:0]  starve_cnt;
    logic              ready_q, starve_q, gnt_err_q;

    logic              push, pop, last_beat, fifo_nonempty;
    logic [LEN_W-1:0]  head_len;
    logic [DATA_W-1:0] head_seed;

    assign head_len      = mem_len[rd_ptr];
    assign head_seed     = mem_seed[rd_ptr];
    assign fifo_nonempty = (count != '0);
    assign push          = cmd_valid && ready_q;

    // Beat path is combinational from gnt so a granted cycle carries data
    assign bus_valid = (state == REQ) && gnt;
    assign last_beat = bus_valid && (beat_idx == head_len);
    assign pop       = last_beat;
    assign bus_last  = last_beat;
    assign bus_data  = bus_valid ? DATA_W'(head_seed + DATA_W'(beat_idx)) : '0;

    assign req       = (state == REQ);
    assign busy      = (state != IDLE) || fifo_nonempty;
    assign cmd_ready = ready_q;
    assign starve    = starve_q;
    assign gnt_err   = gnt_err_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state: request when work is queued, release until grant drops
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fifo_nonempty) state_next = REQ;
            REQ:     if (last_beat) state_next = REL;
            REL:     if (!gnt) state_next = fifo_nonempty ? REQ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + CNT_W'(1);
        else if (!push && pop) count_next = count - CNT_W'(1);
    end

    // Command storage; contents need no reset since pointers gate reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem_len[wr_ptr]  <= cmd_len;
            mem_seed[wr_ptr] <= cmd_seed;
        end
    end

    // FIFO pointers, count and registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count   <= count_next;
            ready_q <= (count_next < DEPTH_C);
        end
    end

    // Beat index: advances per beat, holds across grant gaps, clears on last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         beat_idx <= '0;
        else if (last_beat) beat_idx <= '0;
        else if (bus_valid) beat_idx <= beat_idx + LEN_W'(1);
    end

    // Starvation counter saturating at TIMEOUT with a single pulse on arrival
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            starve_q   <= 1'b0;
        end else if ((state == REQ) && !gnt) begin
            if (starve_cnt != TIMEOUT_C) starve_cnt <= starve_cnt + STV_W'(1);
            starve_q <= (starve_cnt == TIMEOUT_C - STV_W'(1));
        end else begin
            starve_cnt <= '0;
            starve_q   <= 1'b0;
        end
    end

    // Sticky protocol error: grant lost mid-burst or grant while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_err_q <= 1'b0;
        end else if (((state == REQ) && !gnt && (beat_idx != '0)) ||
                     ((state == IDLE) && gnt)) begin
            gnt_err_q <= 1'b1;
        end
    end

endmodule
